// File: rtl/axi_512_to_1024_pkg.sv
// Shared widths, FSM state type and output-beat packing for the 512->1024 stream upsizer.
package axi_512_to_1024_pkg;

  localparam int unsigned IN_BITS  = 512;
  localparam int unsigned OUT_BITS = 2 * IN_BITS;
  localparam int unsigned IN_KEEP  = IN_BITS / 8;
  localparam int unsigned OUT_KEEP = OUT_BITS / 8;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic [OUT_BITS-1:0] data;
    logic [OUT_KEEP-1:0] keep;
    logic                last;
  } out_beat_t;

  // Later beat always lands in the upper half, earlier beat in the lower half.
  function automatic out_beat_t pack_beat(
    input logic [IN_BITS-1:0] hi_data,
    input logic [IN_BITS-1:0] lo_data,
    input logic [IN_KEEP-1:0] hi_keep,
    input logic [IN_KEEP-1:0] lo_keep,
    input logic               last
  );
    out_beat_t b;
    b.data = {hi_data, lo_data};
    b.keep = {hi_keep, lo_keep};
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/axi_512_to_1024.sv
// Packs pairs of 512-bit AXI-Stream beats into 1024-bit beats; odd-length packets
// close with a zero-padded upper half. Single registered output stage, full throughput.
module axi_512_to_1024
  import axi_512_to_1024_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic [IN_KEEP-1:0]  in_keep,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [OUT_KEEP-1:0] out_keep,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
);

  pack_state_e          state_q, state_d;
  logic [IN_BITS-1:0]   low_data_q, low_data_d;
  logic [IN_KEEP-1:0]   low_keep_q, low_keep_d;
  out_beat_t            out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 accept;

  // Ready depends only on the output stage, so there is no valid->ready path.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    low_data_d  = low_data_q;
    low_keep_d  = low_keep_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      ST_LOW: begin
        if (accept) begin
          if (in_last) begin
            out_d       = pack_beat('0, in_data, '0, in_keep, 1'b1);
            out_valid_d = 1'b1;
          end else begin
            low_data_d = in_data;
            low_keep_d = in_keep;
            state_d    = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        if (accept) begin
          out_d       = pack_beat(in_data, low_data_q, in_keep, low_keep_q, in_last);
          out_valid_d = 1'b1;
          state_d     = ST_LOW;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOW;
      low_data_q  <= '0;
      low_keep_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_data_q  <= low_data_d;
      low_keep_q  <= low_keep_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_q.data;
  assign out_keep  = out_q.keep;
  assign out_last  = out_q.last;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_axi_512_to_1024.sv
// Self-checking bench for the 512->1024 upsizer: directed packets, back-pressure,
// reset behaviour and randomized traffic against a packet-level pairing model.
module tb_axi_512_to_1024;
  import axi_512_to_1024_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [IN_BITS-1:0]  in_data;
  logic [IN_KEEP-1:0]  in_keep;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [OUT_BITS-1:0] out_data;
  logic [OUT_KEEP-1:0] out_keep;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_512_to_1024 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  function automatic logic [IN_BITS-1:0] rand_data();
    logic [IN_BITS-1:0] r;
    for (int i = 0; i < IN_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [IN_KEEP-1:0] rand_keep();
    logic [IN_KEEP-1:0] r;
    for (int i = 0; i < IN_KEEP / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IN_BITS-1:0] d, input logic [IN_KEEP-1:0] k,
                       input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    in_keep  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle_in();
    repeat (2) step();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid act=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last act=%b exp=0", out_last); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data act=%0h exp=0", out_data); end
    total++; if (out_keep !== '0) begin bad++; $display("FAIL reset_keep act=%0h exp=0", out_keep); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_four_beat();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(IN_BITS'(i + 1), '1, i == 3);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL four_in_ready beat=%0d act=%b exp=1", i, in_ready); end
      if (i == 2) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL four_b0_valid act=%b exp=1", out_valid); end
        total++; if (out_data[IN_BITS-1:0] !== IN_BITS'(1)) begin bad++; $display("FAIL four_b0_lo act=%0h exp=1", out_data[IN_BITS-1:0]); end
        total++; if (out_data[OUT_BITS-1:IN_BITS] !== IN_BITS'(2)) begin bad++; $display("FAIL four_b0_hi act=%0h exp=2", out_data[OUT_BITS-1:IN_BITS]); end
        total++; if (out_keep !== {OUT_KEEP{1'b1}} || out_last !== 1'b0) begin bad++; $display("FAIL four_b0_keep_last act=%0h/%b exp=all1/0", out_keep, out_last); end
      end
      if (i == 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL four_gap_valid act=%b exp=0", out_valid); end
      end
      step();
    end
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL four_b1_valid_last act=%b/%b exp=1/1", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== IN_BITS'(3)) begin bad++; $display("FAIL four_b1_lo act=%0h exp=3", out_data[IN_BITS-1:0]); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== IN_BITS'(4)) begin bad++; $display("FAIL four_b1_hi act=%0h exp=4", out_data[OUT_BITS-1:IN_BITS]); end
    total++; if (out_keep !== {OUT_KEEP{1'b1}}) begin bad++; $display("FAIL four_b1_keep act=%0h exp=all1", out_keep); end
    step();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL four_drain act=%b exp=0", out_valid); end
    step();
  endtask

  task automatic test_three_beat();
    logic [IN_BITS-1:0] a, b, c;
    a = rand_data(); b = rand_data(); c = rand_data();
    out_ready = 1'b1;
    drive(a, '1, 1'b0); step();
    drive(b, '1, 1'b0); step();
    drive(c, '1, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin bad++; $display("FAIL three_b0_valid_last act=%b/%b exp=1/0", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== a) begin bad++; $display("FAIL three_b0_lo act=%h exp=%h", out_data[IN_BITS-1:0], a); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== b) begin bad++; $display("FAIL three_b0_hi act=%h exp=%h", out_data[OUT_BITS-1:IN_BITS], b); end
    step();
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL three_b1_valid_last act=%b/%b exp=1/1", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== c) begin bad++; $display("FAIL three_b1_lo act=%h exp=%h", out_data[IN_BITS-1:0], c); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== '0) begin bad++; $display("FAIL three_b1_pad act=%h exp=0", out_data[OUT_BITS-1:IN_BITS]); end
    total++; if (out_keep !== {{IN_KEEP{1'b0}}, {IN_KEEP{1'b1}}}) begin bad++; $display("FAIL three_b1_keep act=%h exp=lower-half-ones", out_keep); end
    step();
  endtask

  task automatic test_one_beat();
    logic [IN_BITS-1:0]  d;
    logic [OUT_KEEP-1:0] ek;
    d  = rand_data();
    ek = OUT_KEEP'(8'h0F);
    out_ready = 1'b1;
    drive(d, IN_KEEP'(8'h0F), 1'b1);
    step();
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL one_valid_last act=%b/%b exp=1/1", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== d) begin bad++; $display("FAIL one_lo act=%h exp=%h", out_data[IN_BITS-1:0], d); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== '0) begin bad++; $display("FAIL one_pad act=%h exp=0", out_data[OUT_BITS-1:IN_BITS]); end
    total++; if (out_keep !== ek) begin bad++; $display("FAIL one_keep act=%h exp=%h", out_keep, ek); end
    step();
  endtask

  task automatic test_backpressure();
    logic [IN_BITS-1:0] x, y, z, w;
    x = rand_data(); y = rand_data(); z = rand_data(); w = rand_data();
    out_ready = 1'b0;
    drive(x, '1, 1'b0); step();
    drive(y, '1, 1'b0); step();
    drive(z, '1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d act=%b exp=1", c, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d act=%b exp=0", c, in_ready); end
      total++; if (out_data[IN_BITS-1:0] !== x) begin bad++; $display("FAIL bp_lo cyc=%0d act=%h exp=%h", c, out_data[IN_BITS-1:0], x); end
      total++; if (out_data[OUT_BITS-1:IN_BITS] !== y || out_last !== 1'b0) begin bad++; $display("FAIL bp_hi cyc=%0d act=%h exp=%h", c, out_data[OUT_BITS-1:IN_BITS], y); end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release act=%b/%b exp=1/1", in_ready, out_valid); end
    step();
    drive(w, '1, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup act=%b exp=0", out_valid); end
    step();
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL bp_next_valid_last act=%b/%b exp=1/1", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== z) begin bad++; $display("FAIL bp_next_lo act=%h exp=%h", out_data[IN_BITS-1:0], z); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== w) begin bad++; $display("FAIL bp_next_hi act=%h exp=%h", out_data[OUT_BITS-1:IN_BITS], w); end
    step();
  endtask

  task automatic test_reset_mid_packet();
    logic [IN_BITS-1:0] n1, n2;
    n1 = rand_data(); n2 = rand_data();
    // Pending output under back-pressure, then reset.
    out_ready = 1'b0;
    drive(rand_data(), '1, 1'b0); step();
    drive(rand_data(), '1, 1'b0); step();
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pending_setup act=%b exp=1", out_valid); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL rst_mid_valid_last act=%b/%b exp=0/0", out_valid, out_last); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_mid_data act=%0h exp=0", out_data); end
    step();
    // Held low half, then reset; the next packet must pair its own beats.
    out_ready = 1'b1;
    drive(rand_data(), '1, 1'b0); step();
    idle_in();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(n1, '1, 1'b0); step();
    drive(n2, '1, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_emit act=%b exp=0", out_valid); end
    step();
    idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL rst_new_valid_last act=%b/%b exp=1/1", out_valid, out_last); end
    total++; if (out_data[IN_BITS-1:0] !== n1) begin bad++; $display("FAIL rst_new_lo act=%h exp=%h", out_data[IN_BITS-1:0], n1); end
    total++; if (out_data[OUT_BITS-1:IN_BITS] !== n2) begin bad++; $display("FAIL rst_new_hi act=%h exp=%h", out_data[OUT_BITS-1:IN_BITS], n2); end
    step();
  endtask

  task automatic test_random();
    logic [IN_BITS-1:0]  din_q[$];
    logic [IN_KEEP-1:0]  kin_q[$];
    bit                  lin_q[$];
    logic [OUT_BITS-1:0] dexp_q[$];
    logic [OUT_KEEP-1:0] kexp_q[$];
    bit                  lexp_q[$];
    for (int phase = 0; phase < 2; phase++) begin
      int npkt, pct, budget, cyc, lasts, outb, expb, stalls;
      bit fired;
      logic [IN_BITS-1:0] prev_d;
      logic [IN_KEEP-1:0] prev_k;
      npkt   = (phase == 0) ? 1000 : 100;
      pct    = (phase == 0) ? 50 : 100;
      budget = (phase == 0) ? 70000 : 4000;
      expb = 0;
      for (int p = 0; p < npkt; p++) begin
        int len;
        len = $urandom_range(20, 1);
        for (int b = 0; b < len; b++) begin
          logic [IN_BITS-1:0] d;
          logic [IN_KEEP-1:0] k;
          d = rand_data();
          k = rand_keep();
          din_q.push_back(d); kin_q.push_back(k); lin_q.push_back(b == len - 1);
          if (b % 2 == 1) begin
            dexp_q.push_back({d, prev_d}); kexp_q.push_back({k, prev_k});
            lexp_q.push_back(b == len - 1); expb++;
          end else if (b == len - 1) begin
            dexp_q.push_back({{IN_BITS{1'b0}}, d}); kexp_q.push_back({{IN_KEEP{1'b0}}, k});
            lexp_q.push_back(1'b1); expb++;
          end
          prev_d = d;
          prev_k = k;
        end
      end
      cyc = 0; lasts = 0; outb = 0; stalls = 0; fired = 1'b0;
      idle_in();
      while ((din_q.size() > 0 || dexp_q.size() > 0) && cyc < budget) begin
        if (fired) begin
          void'(din_q.pop_front()); void'(kin_q.pop_front()); void'(lin_q.pop_front());
          in_valid = 1'b0;
        end
        if (din_q.size() > 0) begin
          if (!in_valid) in_valid = ($urandom_range(99) < pct);
          in_data = din_q[0]; in_keep = kin_q[0]; in_last = lin_q[0];
        end else begin
          idle_in();
        end
        out_ready = ($urandom_range(99) < pct);
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (dexp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rnd_extra_beat phase=%0d act=valid exp=no_beat", phase);
          end else begin
            total++; if (out_data[IN_BITS-1:0] !== dexp_q[0][IN_BITS-1:0]) begin bad++; $display("FAIL rnd_lo beat=%0d act=%h exp=%h", outb, out_data[IN_BITS-1:0], dexp_q[0][IN_BITS-1:0]); end
            total++; if (out_data[OUT_BITS-1:IN_BITS] !== dexp_q[0][OUT_BITS-1:IN_BITS]) begin bad++; $display("FAIL rnd_hi beat=%0d act=%h exp=%h", outb, out_data[OUT_BITS-1:IN_BITS], dexp_q[0][OUT_BITS-1:IN_BITS]); end
            total++; if (out_keep !== kexp_q[0] || out_last !== lexp_q[0]) begin bad++; $display("FAIL rnd_keep_last beat=%0d act=%h/%b exp=%h/%b", outb, out_keep, out_last, kexp_q[0], lexp_q[0]); end
            void'(dexp_q.pop_front()); void'(kexp_q.pop_front()); void'(lexp_q.pop_front());
            if (out_last) lasts++;
            outb++;
          end
        end
        if (in_valid && !in_ready) stalls++;
        fired = in_valid && in_ready;
        cyc++;
        step();
      end
      if (fired) begin
        void'(din_q.pop_front()); void'(kin_q.pop_front()); void'(lin_q.pop_front());
      end
      idle_in();
      total++; if (cyc >= budget) begin bad++; $display("FAIL rnd_timeout phase=%0d act=%0d_left exp=0_left", phase, dexp_q.size()); end
      total++; if (lasts !== npkt) begin bad++; $display("FAIL rnd_last_count phase=%0d act=%0d exp=%0d", phase, lasts, npkt); end
      total++; if (outb !== expb) begin bad++; $display("FAIL rnd_beat_count phase=%0d act=%0d exp=%0d", phase, outb, expb); end
      if (phase == 1) begin
        total++; if (stalls !== 0) begin bad++; $display("FAIL rnd_full_rate_stalls act=%0d exp=0", stalls); end
      end
      din_q.delete(); kin_q.delete(); lin_q.delete();
      dexp_q.delete(); kexp_q.delete(); lexp_q.delete();
    end
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    test_reset();
    test_four_beat();
    test_three_beat();
    test_one_beat();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
